trap_filter_peak: RTL

- Parametrised successor to the fixed-version shaping filters fed by exp_sig_gen.
- Implements a trapezoidal (Jordanov) shaper with generic rise/flat lengths, a pole-zero constant, output scaling and saturation.
- Adds a valid-qualified input, a synchronous clear, and a threshold peak detector that reports amplitude, timestamp and pile-up.
- Sits between exp_sig_gen (or the ADC) and the readout logic in the filter top level.

---
 rtl/trap_filter_peak.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/trap_filter_peak.sv
// Trapezoidal (Jordanov) shaper with pole-zero correction, output scaling/saturation,
// and a threshold peak detector reporting amplitude, timestamp and pile-up.
module trap_filter_peak #(
  parameter int SIZE_ADC_DATA    = 14,
  parameter int SIZE_FILTER_DATA = 24,
  parameter int K                = 4,
  parameter int L                = 6,
  parameter int M                = 0,
  parameter int OUT_SHIFT        = 0,
  parameter int THRESHOLD        = 150,
  parameter int MAX_WIDTH        = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               in_valid,
  input  logic [SIZE_ADC_DATA-1:0]           input_data,
  output logic signed [SIZE_FILTER_DATA-1:0] output_data,
  output logic                               output_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_value,
  output logic [31:0]                        peak_time,
  output logic                               peak_pileup,
  output logic                               peak_valid
);

  localparam int DW    = SIZE_ADC_DATA + 2;
  localparam int AW    = 48;
  localparam int FW    = SIZE_FILTER_DATA;
  localparam int DEPTH = K + L;
  localparam logic signed [16:0]   M_S     = 17'(M);
  localparam logic signed [AW-1:0] SAT_MAX = (48'sd1 <<< (FW - 1)) - 48'sd1;
  localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - 48'sd1;
  localparam logic signed [FW-1:0] THR_S   = FW'(THRESHOLD);

  typedef enum logic [1:0] {IDLE, ARMED, REPORT} state_t;

  // dly[0] holds x[n-1]; the line only advances on qualified samples
  logic [SIZE_ADC_DATA-1:0] dly [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) dly[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) dly[i] <= '0;
    end else if (in_valid) begin
      dly[0] <= input_data;
      for (int i = 1; i < DEPTH; i++) dly[i] <= dly[i-1];
    end
  end

  logic signed [DW-1:0] x0, xk, xl, xkl, d_next;
  assign x0     = $signed({2'b00, input_data});
  assign xk     = $signed({2'b00, dly[K-1]});
  assign xl     = $signed({2'b00, dly[L-1]});
  assign xkl    = $signed({2'b00, dly[DEPTH-1]});
  assign d_next = x0 - xk - xl + xkl;

  logic                 v1, v2, v3;
  logic signed [DW-1:0] d_reg;
  logic signed [AW-1:0] p_reg, md_reg, r_reg, s_reg;

  logic signed [DW+16:0] md_full;
  logic signed [AW-1:0]  d_wide, md_next, p_next, r_next, s_next, shifted;
  logic signed [FW-1:0]  sat_out;

  assign md_full = d_reg * M_S;
  assign md_next = {{(AW-DW-17){md_full[DW+16]}}, md_full};
  assign d_wide  = {{(AW-DW){d_reg[DW-1]}}, d_reg};
  assign p_next  = p_reg + d_wide;
  assign r_next  = p_reg + md_reg;
  assign s_next  = s_reg + r_reg;
  assign shifted = s_next >>> OUT_SHIFT;

  always_comb begin
    sat_out = shifted[FW-1:0];
    if (shifted > SAT_MAX)      sat_out = SAT_MAX[FW-1:0];
    else if (shifted < SAT_MIN) sat_out = SAT_MIN[FW-1:0];
  end

  // Each stage advances only with its own valid tag, so bubbles pass through untouched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; output_valid <= 1'b0;
      d_reg <= '0; p_reg <= '0; md_reg <= '0; r_reg <= '0; s_reg <= '0;
      output_data <= '0;
    end else if (clear) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; output_valid <= 1'b0;
      d_reg <= '0; p_reg <= '0; md_reg <= '0; r_reg <= '0; s_reg <= '0;
      output_data <= '0;
    end else begin
      v1           <= in_valid;
      v2           <= v1;
      v3           <= v2;
      output_valid <= v3;
      if (in_valid) d_reg <= d_next;
      if (v1) begin
        p_reg  <= p_next;
        md_reg <= md_next;
      end
      if (v2) r_reg <= r_next;
      if (v3) begin
        s_reg       <= s_next;
        output_data <= sat_out;
      end
    end
  end

  state_t               state;
  logic [31:0]          counter, cur_time, width_cnt, width_inc;
  logic signed [FW-1:0] cur_peak, best_val;
  logic [31:0]          best_time;
  logic                 above, greater;

  assign above     = output_data > THR_S;
  assign greater   = output_data > cur_peak;
  assign best_val  = greater ? output_data : cur_peak;
  assign best_time = greater ? counter : cur_time;
  assign width_inc = width_cnt + 32'd1;

  // Peak detector works on the registered output; counter is the index of that sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      counter <= '0; cur_time <= '0; width_cnt <= '0; cur_peak <= '0;
      peak_value <= '0; peak_time <= '0; peak_pileup <= 1'b0; peak_valid <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      counter <= '0; cur_time <= '0; width_cnt <= '0; cur_peak <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      if (output_valid) counter <= counter + 32'd1;
      case (state)
        ARMED: begin
          if (output_valid) begin
            cur_peak  <= best_val;
            cur_time  <= best_time;
            width_cnt <= width_inc;
            if (!above || width_inc >= 32'(MAX_WIDTH)) begin
              state       <= REPORT;
              peak_valid  <= 1'b1;
              peak_value  <= best_val;
              peak_time   <= best_time;
              peak_pileup <= above;
            end
          end
        end
        default: begin
          // IDLE and REPORT both accept a new above-threshold sample straight away
          if (output_valid && above) begin
            state     <= ARMED;
            cur_peak  <= output_data;
            cur_time  <= counter;
            width_cnt <= 32'd1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
